// File: rtl/barrier_scroll.sv
// Scrolling barrier playfield: 16 columns shift toward the exit on each tick,
// with LFSR-placed gaps, bird collision detection and a saturating pass score.
module barrier_scroll #(
    parameter int unsigned GAP_H    = 4,
    parameter int unsigned SPACING  = 5,
    parameter int unsigned BIRD_COL = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        pause,
    input  logic [3:0]  bird_row,
    input  logic [3:0]  row_sel,
    output logic [15:0] row_bits,
    output logic        hit,
    output logic [7:0]  score
);

    localparam int unsigned NCOL   = 16;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned CMP_W  = 6;

    logic [NCOL-1:0]    col_valid;
    logic [ROW_W-1:0]   col_gap [NCOL];
    logic [LFSR_W-1:0]  lfsr;
    logic [CNT_W-1:0]   spc_cnt;
    logic               step;
    logic               lfsr_fb;
    logic               inject;
    logic [ROW_W-1:0]   new_gap;

    // Gap test done in a wider width so gap_top+GAP_H never wraps.
    function automatic logic in_gap(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] top);
        logic [CMP_W-1:0] rw;
        logic [CMP_W-1:0] lo;
        logic [CMP_W-1:0] hi;
        rw = CMP_W'(r);
        lo = CMP_W'(top);
        hi = CMP_W'(top) + CMP_W'(GAP_H);
        return (rw >= lo) && (rw < hi);
    endfunction

    assign step    = tick & ~pause;
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign inject  = (spc_cnt == '0);
    assign new_gap = inject ? (ROW_W'({1'b0, lfsr[2:0]}) + ROW_W'(2)) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_valid <= '0;
            for (int i = 0; i < int'(NCOL); i++) begin
                col_gap[i] <= '0;
            end
            lfsr    <= LFSR_W'(8'h5A);
            spc_cnt <= '0;
            score   <= '0;
        end else begin
            // LFSR free-runs so barrier placement does not depend on tick timing.
            lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
            if (step) begin
                col_valid  <= {col_valid[NCOL-2:0], inject};
                col_gap[0] <= new_gap;
                for (int i = 1; i < int'(NCOL); i++) begin
                    col_gap[i] <= col_gap[i-1];
                end
                if (spc_cnt == CNT_W'(SPACING - 1)) begin
                    spc_cnt <= '0;
                end else begin
                    spc_cnt <= spc_cnt + CNT_W'(1);
                end
                // A barrier leaving the bird column counts as passed.
                if (col_valid[BIRD_COL] && (score != {SCORE_W{1'b1}})) begin
                    score <= score + SCORE_W'(1);
                end
            end
        end
    end

    always_comb begin
        row_bits = '0;
        for (int i = 0; i < int'(NCOL); i++) begin
            row_bits[i] = col_valid[i] & ~in_gap(row_sel, col_gap[i]);
        end
        hit = col_valid[BIRD_COL] & ~in_gap(bird_row, col_gap[BIRD_COL]);
    end

endmodule

// File: tb/tb_barrier_scroll.sv
// Randomized self-checking bench for barrier_scroll against a queue-based
// playfield model plus directed scenarios for spacing, hit, pause and saturation.
module tb_barrier_scroll;

    localparam int GAP_H    = 4;
    localparam int SPACING  = 5;
    localparam int BIRD_COL = 12;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        pause;
    logic [3:0]  bird_row;
    logic [3:0]  row_sel;
    logic [15:0] row_bits;
    logic        hit;
    logic [7:0]  score;

    barrier_scroll #(
        .GAP_H(GAP_H),
        .SPACING(SPACING),
        .BIRD_COL(BIRD_COL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .pause(pause),
        .bird_row(bird_row),
        .row_sel(row_sel),
        .row_bits(row_bits),
        .hit(hit),
        .score(score)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: column i is m_gap[i]; -1 marks an empty column.
    int m_gap[$];
    int m_lfsr;
    int m_cnt;
    int m_score;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic bit model_in_gap(input int r, input int top);
        return (r >= top) && (r < top + GAP_H);
    endfunction

    function automatic int exp_row(input int r);
        int v = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_gap[i] >= 0 && !model_in_gap(r, m_gap[i])) v += (1 << i);
        end
        return v;
    endfunction

    function automatic int exp_hit(input int b);
        return (m_gap[BIRD_COL] >= 0 && !model_in_gap(b, m_gap[BIRD_COL])) ? 1 : 0;
    endfunction

    task automatic model_edge(input bit t, input bit p, input bit r);
        int fb;
        if (r) begin
            m_gap.delete();
            for (int i = 0; i < 16; i++) m_gap.push_back(-1);
            m_lfsr = 'h5A;
            m_cnt = 0;
            m_score = 0;
        end else begin
            if (t && !p) begin
                if (m_gap[BIRD_COL] >= 0 && m_score < 255) m_score++;
                void'(m_gap.pop_back());
                m_gap.push_front((m_cnt == 0) ? (m_lfsr % 8) + 2 : -1);
                m_cnt = (m_cnt + 1) % SPACING;
            end
            fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
        end
    endtask

    task automatic cyc(input bit t, input bit p, input bit r);
        tick = t;
        pause = p;
        reset = r;
        @(posedge clk);
        model_edge(t, p, r);
        #1;
        tick = 1'b0;
        pause = 1'b0;
        reset = 1'b0;
    endtask

    task automatic light_check(input string tag);
        int rs;
        int br;
        rs = $urandom_range(0, 15);
        br = $urandom_range(0, 15);
        row_sel = 4'(rs);
        bird_row = 4'(br);
        #1;
        chk({tag, "_row"}, int'(row_bits), exp_row(rs));
        chk({tag, "_hit"}, int'(hit), exp_hit(br));
        chk({tag, "_score"}, int'(score), m_score);
    endtask

    task automatic full_check(input string tag);
        int br;
        for (int r = 0; r < 16; r++) begin
            row_sel = 4'(r);
            #1;
            chk({tag, "_row"}, int'(row_bits), exp_row(r));
        end
        br = $urandom_range(0, 15);
        bird_row = 4'(br);
        #1;
        chk({tag, "_hit"}, int'(hit), exp_hit(br));
        chk({tag, "_score"}, int'(score), m_score);
    endtask

    initial begin
        int guard;
        int saved_score;
        int saved_row0;
        reset = 1'b1;
        tick = 1'b0;
        pause = 1'b0;
        bird_row = '0;
        row_sel = '0;
        for (int i = 0; i < 16; i++) m_gap.push_back(-1);

        cyc(0, 0, 1);
        cyc(1, 1, 1);
        full_check("reset");

        // Idle after reset: empty field.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        full_check("idle");
        row_sel = 4'd0;
        #1;
        chk("idle_row0_zero", int'(row_bits), 0);

        // First tick injects a barrier in column 0.
        cyc(1, 0, 0);
        full_check("tick1");
        row_sel = 4'd15;
        #1;
        chk("tick1_col0_bottom", int'(row_bits), 1);

        // 13 ticks total: barriers in 12, 7, 2 only.
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);
        full_check("tick13");
        row_sel = 4'd0;
        #1;
        chk("tick13_layout", int'(row_bits), 'h1084);

        bird_row = 4'(m_gap[BIRD_COL]);
        #1;
        chk("in_gap_no_hit", int'(hit), 0);
        cyc(1, 0, 0);
        chk("first_pass_score", int'(score), 1);

        // Bring the tick-6 barrier into the bird column.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        bird_row = 4'd0;
        #1;
        chk("top_row_hit", int'(hit), 1);
        bird_row = 4'(m_gap[BIRD_COL]);
        #1;
        chk("gap_top_no_hit", int'(hit), 0);
        bird_row = 4'(m_gap[BIRD_COL] + GAP_H);
        #1;
        chk("below_gap_hit", int'(hit), 1);

        // Pause freezes the field and score; ticks during pause are dropped.
        row_sel = 4'd0;
        #1;
        saved_row0 = int'(row_bits);
        saved_score = int'(score);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);
        row_sel = 4'd0;
        #1;
        chk("pause_row0_hold", int'(row_bits), saved_row0);
        chk("pause_score_hold", int'(score), saved_score);
        full_check("pause");
        cyc(1, 0, 0);
        row_sel = 4'd0;
        #1;
        chk("unpause_single_shift", int'(row_bits), ((saved_row0 << 1) & 'hFFFF) | (m_gap[0] >= 0 ? 1 : 0));
        full_check("unpause");

        // Randomized play with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 120) == 0));
            light_check("rand");
        end

        // Continuous ticking until the score saturates.
        guard = 0;
        while (m_score < 255 && guard < 5000) begin
            cyc(1, 0, 0);
            guard++;
        end
        chk("sat_reached", int'(score), 255);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0);
            light_check("sat_run");
        end
        chk("sat_hold", int'(score), 255);

        // Mid-game reset, also with tick asserted.
        cyc(1, 0, 1);
        full_check("midrst");
        chk("midrst_score", int'(score), 0);
        bird_row = 4'd15;
        row_sel = 4'd15;
        #1;
        chk("midrst_hit", int'(hit), 0);
        chk("midrst_row", int'(row_bits), 0);
        cyc(1, 0, 0);
        full_check("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/barrier_scroll.md
BARRIER_SCROLL -- requirements
Module: barrier_scroll

Interface
REQ-001 Parameter GAP_H, default 4, meaning gap height in rows for every barrier.
REQ-002 Parameter SPACING, default 5, meaning ticks between barrier injections; legal range 2..15.
REQ-003 Parameter BIRD_COL, default 12, meaning column index occupied by the bird; legal range 0..14.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  single-cycle scroll enable from the barrier-speed clock divider.
REQ-007 pause  input  1  freeze of playfield and score while high.
REQ-008 bird_row  input  4  current bird row, 0 = top.
REQ-009 row_sel  input  4  playfield row to read.
REQ-010 row_bits  output  16  occupancy of row row_sel; bit i = column i.
REQ-011 hit  output  1  bird overlaps a barrier.
REQ-012 score  output  8  count of barriers passed by the bird.

Function
REQ-013 The block SHALL hold 16 columns, each with a valid bit and a 4-bit gap_top; column 0 is the rightmost (entry) column and column 15 the leftmost (exit).
REQ-014 A column SHALL occupy row r iff valid and r is not within gap_top..gap_top+GAP_H-1.
REQ-015 row_bits SHALL be combinational: bit i = occupancy of column i at row row_sel.
REQ-016 The block SHALL contain an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, that shifts every cycle regardless of tick or pause.
REQ-017 A scroll step SHALL occur on a cycle with tick=1 and pause=0; tick while pause=1 SHALL be ignored and not deferred.
REQ-018 On a scroll step, column i+1 SHALL take column i (i = 0..14), and the old column 15 SHALL be discarded.
REQ-019 On a scroll step, the block SHALL load column 0 with valid=1 and gap_top={1'b0,lfsr[2:0]}+2 when spacing counter = 0, else with valid=0 and gap_top=0.
REQ-020 The spacing counter SHALL advance only on scroll steps, counting 0..SPACING-1 and wrapping to 0.
REQ-021 On a scroll step where column BIRD_COL is valid before the shift, score SHALL increment by 1, saturating at 255.
REQ-022 hit SHALL be combinational: 1 iff column BIRD_COL is valid and bird_row is outside its gap.
REQ-023 hit SHALL NOT stop scrolling; stopping on hit is the game controller's job via pause.
REQ-024 Pause SHALL hold columns, spacing counter and score unchanged, with row_bits and hit still tracking row_sel and bird_row.

Reset
REQ-025 When reset is high, all columns SHALL clear to valid=0, gap_top=0; spacing counter, score and hit SHALL go to 0; LFSR SHALL load 8'h5A.
REQ-026 Reset SHALL take priority over tick and pause on the same cycle.
REQ-027 Reset asserted mid-game SHALL clear state on the next edge with no residual columns.

Verification
REQ-028 Reset, then no tick for 10 cycles -> row_bits=0 for all row_sel, score=0, hit=0.
REQ-029 Reset, one tick -> column 0 valid, gap_top = lfsr[2:0]+2 sampled that cycle; row_bits bit0=1 except at the 4 gap rows.
REQ-030 SPACING=5, 13 ticks -> barriers exactly in columns 12, 7, 2 with all other columns empty; 14th tick with bird_row in the column-12 gap -> hit=0 before the tick, then score=1 after it.
REQ-031 Barrier in BIRD_COL, bird_row=0 with gap_top>=2 -> hit=1; bird_row=gap_top -> hit=0.
REQ-032 pause=1 with 5 ticks -> columns and score unchanged; pause=0 and 1 tick -> single shift.
REQ-033 Force score=255 via a long run -> stays 255 on further passes; reset mid-run -> all outputs 0 on next cycle.
